axis_row_framer: RTL and testbench
==================================

# axis_row_framer

Buffered AXI-stream pass-through that re-frames a token stream into fixed-length rows. It accepts beats on an `axi_stream_if` receiver port and re-transmits them on an `axi_stream_if` transmitter port. It regenerates `tlast` every `ROW_LEN` beats and flags upstream framing mismatches. It sits between compute stages (e.g. matmul output → softmax/layernorm input) to guarantee row boundaries and decouple backpressure.

## Interface
- `D_W`, 32: data width; must match both attached interfaces.
- `ROW_LEN`, 8: beats per row, ≥ 1.
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `CNT_W`, 16: width of `rows_sent`.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `s_axis` `axi_stream_if.axi_in` (D_W): upstream beats; `s_axis.tlast` is checked only, never forwarded.
- `m_axis` `axi_stream_if.axi_out` (D_W): downstream beats with regenerated `tlast`.
- `err_tlast` output 1: one-cycle pulse on an accepted input beat whose `tlast` ≠ the generated `tlast`.
- `rows_sent` output CNT_W: count of output beats transferred with `tlast` = 1; wraps modulo 2^CNT_W.
- `empty` output 1: FIFO holds no entries.

## Operation
- **Input transfer:** `s_axis.tvalid && s_axis.tready` at a rising edge.
  - Push `{tdata, gen_last}` into the FIFO.
  - `gen_last = (in_cnt == ROW_LEN-1)`.
  - `in_cnt` increments, wrapping to 0 after ROW_LEN-1. For ROW_LEN = 1, `gen_last` is always 1.
- **Framing check:** on the same transfer, `err_tlast` is registered high for exactly one cycle if `s_axis.tlast != gen_last`.
  - Framing is not resynchronised; `in_cnt` continues from its own count.
- **Output transfer:** `m_axis.tvalid && m_axis.tready`. Pops the head entry.
  - If the popped entry's `tlast` = 1, `rows_sent` increments.
- **Output port drive:**
  - `m_axis.tvalid = !empty`.
  - `m_axis.tdata` / `m_axis.tlast` = head entry, driven from registered FIFO output.
  - Holding rule: while `tvalid` = 1 and `tready` = 0, `tdata`/`tlast` hold stable.
- **Input port drive:** `s_axis.tready` is a registered `!full` term. It never combinationally depends on `m_axis.tready`.
- **Occupancy:**
  - Simultaneous push and pop leaves occupancy unchanged. This is legal at any occupancy where `s_axis.tready` = 1.
  - When full, `s_axis.tready` = 0, so no push occurs even if a pop occurs that cycle. `tready` returns to 1 the cycle after the pop.
- **Pointers:** read/write pointers are log2(DEPTH) bits and wrap naturally. An occupancy counter (log2(DEPTH)+1 bits) distinguishes full from empty.
- **Reset:** asserting `rst_n` mid-row or mid-packet discards all FIFO contents and clears `in_cnt`. The next accepted beat is beat 0 of a new row.

## Timing
- **Reset values** (held while `rst_n` = 0):
  - `s_axis.tready` = 0, `m_axis.tvalid` = 0, `m_axis.tlast` = 0, `m_axis.tdata` = 0.
  - `err_tlast` = 0, `rows_sent` = 0, `empty` = 1, `in_cnt` = 0.
- **After reset release:** `s_axis.tready` rises on the first rising edge after `rst_n` deasserts.
- **Latency:** a beat accepted at edge k is presented on `m_axis` (`tvalid` = 1) after edge k, i.e. one cycle later. There is no combinational bypass.
- **Throughput:** one beat per cycle sustained when `m_axis.tready` = 1 continuously.
- **Error timing:** `err_tlast` asserts in the cycle following the offending transfer.
- **Row counter timing:** `rows_sent` updates in the cycle following the `tlast` pop.

## Structure
- **Shared package `axis_pkg`:**
  - `axis_beat_t` packed struct `{logic signed [D_W-1:0] tdata; logic tlast;}`, parameterised via a typedef in the module.
  - `clog2`-based localparam helpers for pointer and counter widths.
- **Sub-module `axis_sync_fifo`:** generic DEPTH×width synchronous FIFO with push/pop/full/empty/head.
- **`axis_row_framer` itself:** holds `in_cnt`, the framing check, `rows_sent`, and the interface glue.

## Test plan
- **Straight-through, no backpressure:** ROW_LEN = 4, 12 beats with data 1..12 and correct input `tlast`, `m_axis.tready` = 1.
  - Outputs 1..12 with `tlast` on 4, 8, 12.
  - `rows_sent` = 3, `err_tlast` never high, one-cycle latency.
- **Backpressure fill:** DEPTH = 4, `m_axis.tready` = 0, source always valid.
  - Exactly 4 beats accepted, then `s_axis.tready` = 0.
  - Raise `m_axis.tready`: data order preserved, `s_axis.tready` returns to 1 one cycle after the first pop.
- **Framing error:** ROW_LEN = 4, input `tlast` asserted on beat 3 instead of 4.
  - `err_tlast` pulses once for beat 3 and once for beat 4.
  - Output `tlast` still on beat 4.
- **Random valid/ready:** 50% `tvalid`, 50% `tready`, 1000 beats, ROW_LEN = 5.
  - Scoreboard matches data exactly.
  - Output `tlast` on every 5th beat, `rows_sent` = 200.
  - `tdata` stable whenever `tvalid` is high and `tready` is low.
- **Reset mid-row:** after 2 beats of a 4-beat row with 2 still queued, pulse `rst_n` low.
  - All outputs at reset values, `empty` = 1.
  - The next 4 beats produce `tlast` on the 4th.
- **ROW_LEN = 1:** every output beat has `tlast` = 1, and `rows_sent` equals the beat count.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared width helpers for the AXI-stream framing blocks.
package axis_pkg;

    // Width of an index into n items; never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy counter width: one extra bit separates full from empty.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle with receiver and transmitter views.
interface axi_stream_if #(
    parameter int D_W = 32
);
    logic [D_W-1:0] tdata;
    logic           tvalid;
    logic           tready;
    logic           tlast;

    modport axi_in  (input  tdata, tvalid, tlast, output tready);
    modport axi_out (output tdata, tvalid, tlast, input  tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with a registered head word and a registered full flag,
// so neither output depends combinationally on push or pop.
module axis_sync_fifo
    import axis_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = index_width(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_next_rd;
    logic [OCC_W-1:0] w_count_next;

    assign w_push       = i_push && !r_full;
    assign w_pop        = i_pop && (r_count != '0);
    assign w_next_rd    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    assign w_count_next = r_count + OCC_W'(w_push) - OCC_W'(w_pop);

    // NOTE: the storage array has no reset; validity is tracked by r_count,
    // so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b1;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_next_rd;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == FULL_CNT);
            // When the new head is the word being written, take it from the input.
            if (w_count_next != '0) begin
                r_head <= (w_push && (w_next_rd == r_wr_ptr)) ? i_din : r_mem[w_next_rd];
            end
        end
    end

    assign o_head  = r_head;
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/axis_row_framer.sv
// Buffered AXI-stream pass-through that regenerates tlast every ROW_LEN beats
// and flags upstream beats whose tlast disagrees with the local row count.
module axis_row_framer
    import axis_pkg::*;
#(
    parameter int D_W     = 32,
    parameter int ROW_LEN = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_stream_if.axi_in     s_axis,
    axi_stream_if.axi_out    m_axis,
    output logic             err_tlast,
    output logic [CNT_W-1:0] rows_sent,
    output logic             empty
);
    localparam int IDX_W = index_width(ROW_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

    typedef struct packed {
        logic signed [D_W-1:0] tdata;
        logic                  tlast;
    } axis_beat_t;

    axis_beat_t       w_din;
    axis_beat_t       w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_gen_last;

    logic [IDX_W-1:0] r_in_cnt;
    logic             r_err_tlast;
    logic [CNT_W-1:0] r_rows_sent;

    assign w_gen_last = (r_in_cnt == LAST_IDX);
    assign w_push     = s_axis.tvalid && !w_full;
    assign w_pop      = !w_empty && m_axis.tready;
    assign w_din      = '{tdata: s_axis.tdata, tlast: w_gen_last};

    // The row count free-runs; an upstream tlast mismatch is reported, not obeyed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt    <= '0;
            r_err_tlast <= 1'b0;
            r_rows_sent <= '0;
        end else begin
            if (w_push) begin
                r_in_cnt <= w_gen_last ? '0 : r_in_cnt + IDX_W'(1);
            end
            r_err_tlast <= w_push && (s_axis.tlast != w_gen_last);
            if (w_pop && w_head.tlast) begin
                r_rows_sent <= r_rows_sent + CNT_W'(1);
            end
        end
    end

    axis_sync_fifo #(
        .WIDTH ($bits(axis_beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign s_axis.tready = !w_full;
    assign m_axis.tvalid = !w_empty;
    assign m_axis.tdata  = w_head.tdata;
    assign m_axis.tlast  = w_head.tlast;
    assign err_tlast     = r_err_tlast;
    assign rows_sent     = r_rows_sent;
    assign empty         = w_empty;
endmodule

// File: tb/tb_axis_row_framer.sv
// Directed scenario bench for axis_row_framer at ROW_LEN 4, 5 and 1.
module tb_axis_row_framer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axi_stream_if #(.D_W(32)) s4 ();
    axi_stream_if #(.D_W(32)) m4 ();
    axi_stream_if #(.D_W(32)) s5 ();
    axi_stream_if #(.D_W(32)) m5 ();
    axi_stream_if #(.D_W(32)) s1 ();
    axi_stream_if #(.D_W(32)) m1 ();

    logic        err4, err5, err1;
    logic [15:0] rows4, rows5, rows1;
    logic        empty4, empty5, empty1;

    axis_row_framer #(.D_W(32), .ROW_LEN(4), .DEPTH(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .s_axis(s4), .m_axis(m4),
        .err_tlast(err4), .rows_sent(rows4), .empty(empty4));
    axis_row_framer #(.D_W(32), .ROW_LEN(5), .DEPTH(4), .CNT_W(16)) dut5 (
        .clk(clk), .rst_n(rst_n), .s_axis(s5), .m_axis(m5),
        .err_tlast(err5), .rows_sent(rows5), .empty(empty5));
    axis_row_framer #(.D_W(32), .ROW_LEN(1), .DEPTH(4), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1),
        .err_tlast(err1), .rows_sent(rows1), .empty(empty1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        s4.tvalid = 0; s4.tdata = '0; s4.tlast = 0; m4.tready = 0;
        s5.tvalid = 0; s5.tdata = '0; s5.tlast = 0; m5.tready = 0;
        s1.tvalid = 0; s1.tdata = '0; s1.tlast = 0; m1.tready = 0;
    endtask

    task automatic apply_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (s4.tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %0b expected 0", s4.tready); end
        checks++; if (m4.tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %0b expected 0", m4.tvalid); end
        checks++; if (m4.tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast: got %0b expected 0", m4.tlast); end
        checks++; if (m4.tdata !== 32'h0) begin errors++; $display("FAIL reset_m_tdata: got %0h expected 0", m4.tdata); end
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err4); end
        checks++; if (rows4 !== 16'd0) begin errors++; $display("FAIL reset_rows: got %0d expected 0", rows4); end
        checks++; if (empty4 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty4); end
        rst_n = 1'b1;
        #2;
        checks++; if (s4.tready !== 1'b0) begin errors++; $display("FAIL release_tready_before_edge: got %0b expected 0", s4.tready); end
        tick();
        checks++; if (s4.tready !== 1'b1) begin errors++; $display("FAIL release_tready_after_edge: got %0b expected 1", s4.tready); end
    endtask

    task automatic test_straight();
        int in_idx = 0;
        int out_idx = 0;
        bit err_seen = 0;
        bit in_x, out_x;
        apply_reset();
        m4.tready = 1;
        for (int cyc = 0; cyc < 30 && out_idx < 12; cyc++) begin
            s4.tvalid = (in_idx < 12);
            s4.tdata  = 32'(in_idx + 1);
            s4.tlast  = ((in_idx + 1) % 4 == 0);
            in_x  = s4.tvalid && s4.tready;
            out_x = m4.tvalid && m4.tready;
            if (out_x) begin
                checks++; if (m4.tdata !== 32'(out_idx + 1)) begin errors++; $display("FAIL straight_data: got %0d expected %0d", m4.tdata, out_idx + 1); end
                checks++; if (m4.tlast !== ((out_idx + 1) % 4 == 0)) begin errors++; $display("FAIL straight_tlast beat %0d: got %0b", out_idx + 1, m4.tlast); end
                checks++; if (cyc != out_idx + 1) begin errors++; $display("FAIL straight_latency beat %0d: seen in cycle %0d expected %0d", out_idx + 1, cyc, out_idx + 1); end
            end
            tick();
            if (in_x) in_idx++;
            if (out_x) out_idx++;
            if (err4) err_seen = 1;
        end
        s4.tvalid = 0;
        checks++; if (out_idx != 12) begin errors++; $display("FAIL straight_count: got %0d expected 12", out_idx); end
        checks++; if (rows4 !== 16'd3) begin errors++; $display("FAIL straight_rows: got %0d expected 3", rows4); end
        checks++; if (err_seen) begin errors++; $display("FAIL straight_err: got 1 expected 0"); end
        checks++; if (empty4 !== 1'b1) begin errors++; $display("FAIL straight_empty: got %0b expected 1", empty4); end
    endtask

    task automatic test_backpressure();
        int in_idx = 0;
        int out_idx = 0;
        bit in_x, out_x, first_pop;
        apply_reset();
        m4.tready = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            s4.tvalid = 1;
            s4.tdata  = 32'(100 + in_idx);
            s4.tlast  = (in_idx % 4 == 3);
            in_x = s4.tvalid && s4.tready;
            tick();
            if (in_x) in_idx++;
            if (m4.tvalid) begin
                checks++; if (m4.tdata !== 32'd100) begin errors++; $display("FAIL bp_hold_data: got %0d expected 100", m4.tdata); end
            end
        end
        checks++; if (in_idx != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", in_idx); end
        checks++; if (s4.tready !== 1'b0) begin errors++; $display("FAIL bp_full_tready: got %0b expected 0", s4.tready); end
        checks++; if (empty4 !== 1'b0) begin errors++; $display("FAIL bp_full_empty: got %0b expected 0", empty4); end
        m4.tready = 1;
        first_pop = 1;
        for (int cyc = 0; cyc < 40 && out_idx < 12; cyc++) begin
            s4.tvalid = (in_idx < 12);
            s4.tdata  = 32'(100 + in_idx);
            s4.tlast  = (in_idx % 4 == 3);
            in_x  = s4.tvalid && s4.tready;
            out_x = m4.tvalid && m4.tready;
            if (out_x) begin
                checks++; if (m4.tdata !== 32'(100 + out_idx)) begin errors++; $display("FAIL bp_data: got %0d expected %0d", m4.tdata, 100 + out_idx); end
                checks++; if (m4.tlast !== (out_idx % 4 == 3)) begin errors++; $display("FAIL bp_tlast beat %0d: got %0b", out_idx, m4.tlast); end
            end
            tick();
            if (in_x) in_idx++;
            if (out_x) out_idx++;
            if (first_pop && out_x) begin
                first_pop = 0;
                checks++; if (s4.tready !== 1'b1) begin errors++; $display("FAIL bp_tready_return: got %0b expected 1", s4.tready); end
            end
        end
        s4.tvalid = 0;
        checks++; if (out_idx != 12) begin errors++; $display("FAIL bp_count: got %0d expected 12", out_idx); end
        checks++; if (rows4 !== 16'd3) begin errors++; $display("FAIL bp_rows: got %0d expected 3", rows4); end
    endtask

    task automatic test_framing();
        int in_idx = 0;
        int out_idx = 0;
        int pulses = 0;
        bit in_x, out_x, exp_err;
        apply_reset();
        m4.tready = 1;
        for (int cyc = 0; cyc < 20 && (out_idx < 4 || cyc < 8); cyc++) begin
            s4.tvalid = (in_idx < 4);
            s4.tdata  = 32'(200 + in_idx);
            s4.tlast  = (in_idx == 2);
            in_x    = s4.tvalid && s4.tready;
            out_x   = m4.tvalid && m4.tready;
            exp_err = in_x && (s4.tlast != (in_idx % 4 == 3));
            if (out_x) begin
                checks++; if (m4.tlast !== (out_idx == 3)) begin errors++; $display("FAIL frame_tlast beat %0d: got %0b", out_idx, m4.tlast); end
            end
            tick();
            if (in_x) in_idx++;
            if (out_x) out_idx++;
            if (err4) pulses++;
            checks++; if (err4 !== exp_err) begin errors++; $display("FAIL frame_err cycle %0d: got %0b expected %0b", cyc, err4, exp_err); end
        end
        s4.tvalid = 0;
        checks++; if (pulses != 2) begin errors++; $display("FAIL frame_pulses: got %0d expected 2", pulses); end
        checks++; if (rows4 !== 16'd1) begin errors++; $display("FAIL frame_rows: got %0d expected 1", rows4); end
    endtask

    task automatic test_random();
        int in_idx = 0;
        int out_idx = 0;
        bit in_x, out_x, hold_pend, err_seen;
        logic [31:0] held_data;
        logic        held_last;
        hold_pend = 0;
        err_seen = 0;
        apply_reset();
        for (int cyc = 0; cyc < 20000 && out_idx < 1000; cyc++) begin
            s5.tvalid = (in_idx < 1000) && ($urandom_range(0, 1) == 1);
            s5.tdata  = 32'(in_idx * 13 + 7);
            s5.tlast  = (in_idx % 5 == 4);
            m5.tready = ($urandom_range(0, 1) == 1);
            if (hold_pend) begin
                checks++;
                if (m5.tvalid !== 1'b1 || m5.tdata !== held_data || m5.tlast !== held_last) begin
                    errors++; $display("FAIL rand_hold: got %0b/%0h/%0b expected 1/%0h/%0b", m5.tvalid, m5.tdata, m5.tlast, held_data, held_last);
                end
            end
            in_x  = s5.tvalid && s5.tready;
            out_x = m5.tvalid && m5.tready;
            if (out_x) begin
                checks++; if (m5.tdata !== 32'(out_idx * 13 + 7) || m5.tlast !== (out_idx % 5 == 4)) begin
                    errors++; $display("FAIL rand_beat %0d: got %0h/%0b expected %0h/%0b", out_idx, m5.tdata, m5.tlast, 32'(out_idx * 13 + 7), (out_idx % 5 == 4));
                end
            end
            hold_pend = m5.tvalid && !m5.tready;
            held_data = m5.tdata;
            held_last = m5.tlast;
            tick();
            if (in_x) in_idx++;
            if (out_x) out_idx++;
            if (err5) err_seen = 1;
        end
        s5.tvalid = 0;
        m5.tready = 0;
        checks++; if (out_idx != 1000) begin errors++; $display("FAIL rand_count: got %0d expected 1000", out_idx); end
        checks++; if (rows5 !== 16'd200) begin errors++; $display("FAIL rand_rows: got %0d expected 200", rows5); end
        checks++; if (err_seen) begin errors++; $display("FAIL rand_err: got 1 expected 0"); end
    endtask

    task automatic test_reset_mid();
        int in_idx = 0;
        int out_idx = 0;
        bit in_x, out_x, err_seen;
        err_seen = 0;
        apply_reset();
        m4.tready = 0;
        for (int cyc = 0; cyc < 10 && in_idx < 2; cyc++) begin
            s4.tvalid = 1;
            s4.tdata  = 32'(300 + in_idx);
            s4.tlast  = 0;
            in_x = s4.tvalid && s4.tready;
            tick();
            if (in_x) in_idx++;
        end
        s4.tvalid = 0;
        checks++; if (m4.tvalid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %0b expected 1", m4.tvalid); end
        rst_n = 1'b0;
        #1;
        checks++; if (s4.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %0b expected 0", s4.tready); end
        checks++; if (m4.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %0b expected 0", m4.tvalid); end
        checks++; if (m4.tdata !== 32'h0 || m4.tlast !== 1'b0) begin errors++; $display("FAIL mid_rst_head: got %0h/%0b expected 0/0", m4.tdata, m4.tlast); end
        checks++; if (empty4 !== 1'b1) begin errors++; $display("FAIL mid_rst_empty: got %0b expected 1", empty4); end
        tick();
        rst_n = 1'b1;
        tick();
        m4.tready = 1;
        in_idx = 0;
        for (int cyc = 0; cyc < 20 && out_idx < 4; cyc++) begin
            s4.tvalid = (in_idx < 4);
            s4.tdata  = 32'(400 + in_idx);
            s4.tlast  = (in_idx == 3);
            in_x  = s4.tvalid && s4.tready;
            out_x = m4.tvalid && m4.tready;
            if (out_x) begin
                checks++; if (m4.tdata !== 32'(400 + out_idx) || m4.tlast !== (out_idx == 3)) begin
                    errors++; $display("FAIL mid_beat %0d: got %0d/%0b expected %0d/%0b", out_idx, m4.tdata, m4.tlast, 400 + out_idx, (out_idx == 3));
                end
            end
            tick();
            if (in_x) in_idx++;
            if (out_x) out_idx++;
            if (err4) err_seen = 1;
        end
        s4.tvalid = 0;
        checks++; if (out_idx != 4) begin errors++; $display("FAIL mid_count: got %0d expected 4", out_idx); end
        checks++; if (rows4 !== 16'd1) begin errors++; $display("FAIL mid_rows: got %0d expected 1", rows4); end
        checks++; if (err_seen) begin errors++; $display("FAIL mid_err: got 1 expected 0"); end
    endtask

    task automatic test_row1();
        int in_idx = 0;
        int out_idx = 0;
        bit in_x, out_x, err_seen;
        err_seen = 0;
        apply_reset();
        m1.tready = 1;
        for (int cyc = 0; cyc < 30 && out_idx < 6; cyc++) begin
            s1.tvalid = (in_idx < 6) && (cyc % 2 == 0);
            s1.tdata  = 32'(500 + in_idx);
            s1.tlast  = 1;
            in_x  = s1.tvalid && s1.tready;
            out_x = m1.tvalid && m1.tready;
            if (out_x) begin
                checks++; if (m1.tdata !== 32'(500 + out_idx) || m1.tlast !== 1'b1) begin
                    errors++; $display("FAIL row1_beat %0d: got %0d/%0b expected %0d/1", out_idx, m1.tdata, m1.tlast, 500 + out_idx);
                end
            end
            tick();
            if (in_x) in_idx++;
            if (out_x) out_idx++;
            if (err1) err_seen = 1;
        end
        s1.tvalid = 0;
        checks++; if (rows1 !== 16'(out_idx) || out_idx != 6) begin errors++; $display("FAIL row1_rows: got %0d beats %0d expected 6", rows1, out_idx); end
        checks++; if (err_seen) begin errors++; $display("FAIL row1_err: got 1 expected 0"); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_backpressure();
        test_framing();
        test_random();
        test_reset_mid();
        test_row1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
